// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALU ops, branch ops, the multiplier
// FSM states and the ID/EX pipeline register layout.
package mips_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1101;

    localparam logic [2:0] BP_NONE = 3'b000;
    localparam logic [2:0] BP_BEQ  = 3'b001;
    localparam logic [2:0] BP_BNE  = 3'b010;
    localparam logic [2:0] BP_BLEZ = 3'b011;
    localparam logic [2:0] BP_BGTZ = 3'b100;
    localparam logic [2:0] BP_BLTZ = 3'b101;
    localparam logic [2:0] BP_BGEZ = 3'b110;
    localparam logic [2:0] BP_JR   = 3'b111;

    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pcplus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  alu_ctl;
        logic [2:0]  bp_ctl;
        logic        reg_write;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_write;
        logic        mem_to_reg;
        logic        link;
    } idex_t;

    // Logical ops take a zero-extended immediate, everything else sign-extends.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [3:0] alu_ctl);
        if (alu_ctl == ALU_AND || alu_ctl == ALU_OR || alu_ctl == ALU_XOR)
            return {16'h0000, imm};
        else
            return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier (low 32 bits), one bit per cycle.
module mul_iter
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        advance,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [1:0]  state;
    logic [4:0]  count;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

    // FSM, iteration counter and shift-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MUL_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31)
                        state <= MUL_DONE;
                end
                MUL_DONE: begin
                    if (advance)
                        state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    // Busy asserts in the start cycle too, so the stage freezes immediately.
    always_comb begin
        busy    = (state == MUL_BUSY) || (state == MUL_IDLE && start);
        done    = (state == MUL_DONE);
        product = acc;
    end

endmodule

// File: rtl/execute.sv
// EX stage: ID/EX register, ALU, branch/JR resolution and iterative multiply.
module execute
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             AnyStall,
    input  logic             Valid_ID,
    input  logic [WIDTH-1:0] PcPlus4_ID,
    input  logic [WIDTH-1:0] RsData_ID,
    input  logic [WIDTH-1:0] RtData_ID,
    input  logic [15:0]      Imm_ID,
    input  logic [4:0]       Rt_ID,
    input  logic [4:0]       Rd_ID,
    input  logic [3:0]       AluControl_ID,
    input  logic [2:0]       BpCtl_ID,
    input  logic             RegWrite_ID,
    input  logic             RegDst_ID,
    input  logic             AluSrc_ID,
    input  logic             MemWrite_ID,
    input  logic             MemToReg_ID,
    input  logic             Link_ID,
    output logic [WIDTH-1:0] Result_EX,
    output logic [WIDTH-1:0] StoreData_EX,
    output logic [4:0]       DestReg_EX,
    output logic             Valid_EX,
    output logic             RegWrite_EX,
    output logic             MemWrite_EX,
    output logic             MemToReg_EX,
    output logic             BranchTaken_EX,
    output logic [WIDTH-1:0] RedirectPc_EX,
    output logic             MulBusy_EX
);

    idex_t       ex;
    logic [31:0] imm_ext;
    logic [31:0] opb;
    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        cond;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;

    // ID/EX pipeline register: hold on stall/multiply, squash after a redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex <= '0;
        end else if (AnyStall || mul_busy) begin
            ex <= ex;
        end else if (BranchTaken_EX) begin
            ex <= '0;
        end else begin
            ex.valid      <= Valid_ID;
            ex.pcplus4    <= PcPlus4_ID;
            ex.rs_data    <= RsData_ID;
            ex.rt_data    <= RtData_ID;
            ex.imm        <= Imm_ID;
            ex.rt         <= Rt_ID;
            ex.rd         <= Rd_ID;
            ex.alu_ctl    <= AluControl_ID;
            ex.bp_ctl     <= BpCtl_ID;
            ex.reg_write  <= RegWrite_ID;
            ex.reg_dst    <= RegDst_ID;
            ex.alu_src    <= AluSrc_ID;
            ex.mem_write  <= MemWrite_ID;
            ex.mem_to_reg <= MemToReg_ID;
            ex.link       <= Link_ID;
        end
    end

    assign mul_start = ex.valid && (ex.alu_ctl == ALU_MUL);

    mul_iter u_mul (
        .clk     (clk),
        .rst     (reset),
        .start   (mul_start),
        .advance (!AnyStall),
        .a       (ex.rs_data),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // ALU: operand select and op decode
    always_comb begin
        imm_ext = extend_imm(ex.imm, ex.alu_ctl);
        opb     = ex.alu_src ? imm_ext : ex.rt_data;
        shamt   = ex.imm[10:6];
        alu_res = '0;
        case (ex.alu_ctl)
            ALU_AND:  alu_res = ex.rs_data & opb;
            ALU_OR:   alu_res = ex.rs_data | opb;
            ALU_ADD:  alu_res = ex.rs_data + opb;
            ALU_XOR:  alu_res = ex.rs_data ^ opb;
            ALU_NOR:  alu_res = ~(ex.rs_data | opb);
            ALU_SLL:  alu_res = ex.rt_data << shamt;
            ALU_SRL:  alu_res = ex.rt_data >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(ex.rt_data) >>> shamt);
            ALU_SLTU: alu_res = {31'd0, (ex.rs_data < opb)};
            ALU_SUB:  alu_res = ex.rs_data - opb;
            ALU_SLT:  alu_res = {31'd0, ($signed(ex.rs_data) < $signed(opb))};
            ALU_LUI:  alu_res = {ex.imm, 16'h0000};
            ALU_MUL:  alu_res = mul_done ? mul_product : '0;
            default:  alu_res = '0;
        endcase
    end

    // Branch condition evaluation (signed compares on Rs)
    always_comb begin
        cond = 1'b0;
        case (ex.bp_ctl)
            BP_BEQ:  cond = (ex.rs_data == ex.rt_data);
            BP_BNE:  cond = (ex.rs_data != ex.rt_data);
            BP_BLEZ: cond = ($signed(ex.rs_data) <= 0);
            BP_BGTZ: cond = ($signed(ex.rs_data) > 0);
            BP_BLTZ: cond = ex.rs_data[31];
            BP_BGEZ: cond = !ex.rs_data[31];
            BP_JR:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Output qualification, destination select and redirect target
    always_comb begin
        Result_EX      = ex.link ? (ex.pcplus4 + 32'd4) : alu_res;
        StoreData_EX   = ex.rt_data;
        DestReg_EX     = ex.link ? REG_RA : (ex.reg_dst ? ex.rd : ex.rt);
        Valid_EX       = ex.valid;
        RegWrite_EX    = ex.valid && ex.reg_write;
        MemWrite_EX    = ex.valid && ex.mem_write;
        MemToReg_EX    = ex.valid && ex.mem_to_reg;
        BranchTaken_EX = ex.valid && cond;
        RedirectPc_EX  = (ex.bp_ctl == BP_JR) ? ex.rs_data
                       : ex.pcplus4 + {{14{ex.imm[15]}}, ex.imm, 2'b00};
        MulBusy_EX     = mul_busy;
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage: vector table plus multiply/redirect/reset sequences.
module tb_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic        AnyStall;
    logic        Valid_ID;
    logic [31:0] PcPlus4_ID, RsData_ID, RtData_ID;
    logic [15:0] Imm_ID;
    logic [4:0]  Rt_ID, Rd_ID;
    logic [3:0]  AluControl_ID;
    logic [2:0]  BpCtl_ID;
    logic        RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID;
    logic [31:0] Result_EX, StoreData_EX, RedirectPc_EX;
    logic [4:0]  DestReg_EX;
    logic        Valid_EX, RegWrite_EX, MemWrite_EX, MemToReg_EX, BranchTaken_EX, MulBusy_EX;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .AnyStall(AnyStall), .Valid_ID(Valid_ID),
        .PcPlus4_ID(PcPlus4_ID), .RsData_ID(RsData_ID), .RtData_ID(RtData_ID),
        .Imm_ID(Imm_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .AluControl_ID(AluControl_ID), .BpCtl_ID(BpCtl_ID),
        .RegWrite_ID(RegWrite_ID), .RegDst_ID(RegDst_ID), .AluSrc_ID(AluSrc_ID),
        .MemWrite_ID(MemWrite_ID), .MemToReg_ID(MemToReg_ID), .Link_ID(Link_ID),
        .Result_EX(Result_EX), .StoreData_EX(StoreData_EX), .DestReg_EX(DestReg_EX),
        .Valid_EX(Valid_EX), .RegWrite_EX(RegWrite_EX), .MemWrite_EX(MemWrite_EX),
        .MemToReg_EX(MemToReg_EX), .BranchTaken_EX(BranchTaken_EX),
        .RedirectPc_EX(RedirectPc_EX), .MulBusy_EX(MulBusy_EX)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic [2:0]  bp;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  rt_reg;
        logic [4:0]  rd_reg;
        logic [31:0] pc4;
        logic        rw, rdst, asrc, mw, m2r, link;
        logic [31:0] exp_res;
        logic [4:0]  exp_dest;
        logic        exp_taken;
        logic [31:0] exp_redir;
        logic        exp_rw;
        logic        exp_mw;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t nv(input logic [3:0] alu, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] imm);
        vec_t v;
        v = '0;
        v.alu = alu; v.rs = rs; v.rt = rt; v.imm = imm;
        return v;
    endfunction

    task automatic idle_id();
        Valid_ID = 0; PcPlus4_ID = 0; RsData_ID = 0; RtData_ID = 0; Imm_ID = 0;
        Rt_ID = 0; Rd_ID = 0; AluControl_ID = 0; BpCtl_ID = 0; RegWrite_ID = 0;
        RegDst_ID = 0; AluSrc_ID = 0; MemWrite_ID = 0; MemToReg_ID = 0; Link_ID = 0;
    endtask

    task automatic drive(input vec_t v);
        Valid_ID = 1; PcPlus4_ID = v.pc4; RsData_ID = v.rs; RtData_ID = v.rt;
        Imm_ID = v.imm; Rt_ID = v.rt_reg; Rd_ID = v.rd_reg; AluControl_ID = v.alu;
        BpCtl_ID = v.bp; RegWrite_ID = v.rw; RegDst_ID = v.rdst; AluSrc_ID = v.asrc;
        MemWrite_ID = v.mw; MemToReg_ID = v.m2r; Link_ID = v.link;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] alu, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [4:0] rd);
        vec_t v;
        v = nv(alu, rs, rt, 16'h0);
        v.rdst = 1; v.rd_reg = rd; v.rw = 1;
        drive(v);
    endtask

    initial begin
        vec_t v;
        int   n;

        // ---- vector table ----
        v = nv(4'b0010, 5, 7, 0); v.rt_reg = 8; v.rd_reg = 3; v.rdst = 1; v.rw = 1;
        v.exp_res = 12; v.exp_dest = 3; v.exp_rw = 1; vecs.push_back(v);
        v = nv(4'b1010, 5, 7, 0); v.rt_reg = 9; v.rw = 1;
        v.exp_res = 32'hFFFF_FFFE; v.exp_dest = 9; v.exp_rw = 1; vecs.push_back(v);
        v = nv(4'b0000, 32'hFFFF_0F0F, 0, 16'h8F0F); v.asrc = 1; v.rt_reg = 10; v.rw = 1;
        v.exp_res = 32'h0000_0F0F; v.exp_dest = 10; v.exp_rw = 1; vecs.push_back(v);
        v = nv(4'b0010, 32'h10, 0, 16'hFFFF); v.asrc = 1; v.rt_reg = 11; v.rw = 1;
        v.exp_res = 32'hF; v.exp_dest = 11; v.exp_rw = 1; vecs.push_back(v);
        v = nv(4'b0101, 0, 1, 16'h0100); v.rdst = 1; v.rd_reg = 12; v.rw = 1;
        v.exp_res = 32'h10; v.exp_dest = 12; v.exp_rw = 1; vecs.push_back(v);
        v = nv(4'b0111, 0, 32'h8000_0000, 16'h0100);
        v.exp_res = 32'hF800_0000; vecs.push_back(v);
        v = nv(4'b0110, 0, 32'h8000_0000, 16'h07C0);
        v.exp_res = 32'h1; vecs.push_back(v);
        v = nv(4'b1011, 32'hFFFF_FFFF, 1, 0); v.exp_res = 1; vecs.push_back(v);
        v = nv(4'b1000, 32'hFFFF_FFFF, 1, 0); v.exp_res = 0; vecs.push_back(v);
        v = nv(4'b1100, 0, 0, 16'h1234); v.asrc = 1; v.exp_res = 32'h1234_0000; vecs.push_back(v);
        v = nv(4'b0100, 0, 0, 0); v.exp_res = 32'hFFFF_FFFF; vecs.push_back(v);
        v = nv(4'b0011, 32'hF0F0, 32'hFF00, 0); v.exp_res = 32'h0FF0; vecs.push_back(v);
        v = nv(4'b0001, 1, 0, 16'h8000); v.asrc = 1; v.exp_res = 32'h8001; vecs.push_back(v);
        v = nv(4'b1001, 5, 7, 0); v.exp_res = 0; vecs.push_back(v);
        v = nv(4'b1111, 5, 7, 0); v.exp_res = 0; vecs.push_back(v);
        v = nv(4'b0010, 32'h1000, 32'hDEAD_BEEF, 16'hFFFC); v.asrc = 1; v.mw = 1; v.rt_reg = 2;
        v.exp_res = 32'hFFC; v.exp_dest = 2; v.exp_mw = 1; vecs.push_back(v);
        v = nv(4'b0000, 9, 9, 16'h0004); v.bp = 3'b001; v.pc4 = 32'h100;
        v.exp_res = 9; v.exp_taken = 1; v.exp_redir = 32'h110; vecs.push_back(v);
        v = nv(4'b0000, 9, 9, 16'h0004); v.bp = 3'b010; v.pc4 = 32'h100;
        v.exp_res = 9; vecs.push_back(v);
        v = nv(4'b0000, 32'h400, 0, 0); v.bp = 3'b111; v.pc4 = 32'h100;
        v.exp_res = 0; v.exp_taken = 1; v.exp_redir = 32'h400; vecs.push_back(v);
        v = nv(4'b0000, 32'hFFFF_FFFC, 0, 16'hFFFF); v.bp = 3'b101; v.pc4 = 32'h100;
        v.exp_res = 0; v.exp_taken = 1; v.exp_redir = 32'hFC; vecs.push_back(v);
        v = nv(4'b0000, 32'hFFFF_FFFC, 0, 16'hFFFF); v.bp = 3'b110; v.pc4 = 32'h100;
        v.exp_res = 0; vecs.push_back(v);
        v = nv(4'b0000, 0, 0, 16'h0002); v.bp = 3'b011; v.pc4 = 32'h200;
        v.exp_res = 0; v.exp_taken = 1; v.exp_redir = 32'h208; vecs.push_back(v);
        v = nv(4'b0000, 0, 0, 16'h0002); v.bp = 3'b100; v.pc4 = 32'h200;
        v.exp_res = 0; vecs.push_back(v);
        v = nv(4'b0000, 1, 0, 16'hFFFE); v.bp = 3'b100; v.pc4 = 32'h300;
        v.exp_res = 0; v.exp_taken = 1; v.exp_redir = 32'h2F8; vecs.push_back(v);
        v = nv(4'b0010, 3, 4, 0); v.link = 1; v.pc4 = 32'h200; v.rw = 1;
        v.exp_res = 32'h204; v.exp_dest = 31; v.exp_rw = 1; vecs.push_back(v);

        // ---- reset state ----
        reset = 1; AnyStall = 0; idle_id();
        step(); step();
        check("reset_result", Result_EX, 0);
        check("reset_valid", {31'd0, Valid_EX}, 0);
        check("reset_taken", {31'd0, BranchTaken_EX}, 0);
        check("reset_mulbusy", {31'd0, MulBusy_EX}, 0);
        check("reset_regwrite", {31'd0, RegWrite_EX}, 0);
        reset = 0;
        step();

        // ---- table ----
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d_result", i), Result_EX, vecs[i].exp_res);
            check($sformatf("v%0d_dest", i), {27'd0, DestReg_EX}, {27'd0, vecs[i].exp_dest});
            check($sformatf("v%0d_valid", i), {31'd0, Valid_EX}, 1);
            check($sformatf("v%0d_taken", i), {31'd0, BranchTaken_EX}, {31'd0, vecs[i].exp_taken});
            if (vecs[i].exp_taken)
                check($sformatf("v%0d_redirect", i), RedirectPc_EX, vecs[i].exp_redir);
            check($sformatf("v%0d_regwrite", i), {31'd0, RegWrite_EX}, {31'd0, vecs[i].exp_rw});
            check($sformatf("v%0d_memwrite", i), {31'd0, MemWrite_EX}, {31'd0, vecs[i].exp_mw});
            check($sformatf("v%0d_storedata", i), StoreData_EX, vecs[i].rt);
            idle_id();
            step();
        end

        // ---- taken BEQ squashes the following ID instruction ----
        v = nv(4'b0000, 9, 9, 16'h0004); v.bp = 3'b001; v.pc4 = 32'h100;
        drive(v);
        step();
        check("beq_taken", {31'd0, BranchTaken_EX}, 1);
        drive_alu(4'b0010, 5, 7, 3);
        step();
        check("bubble_valid", {31'd0, Valid_EX}, 0);
        check("bubble_regwrite", {31'd0, RegWrite_EX}, 0);
        check("bubble_taken", {31'd0, BranchTaken_EX}, 0);
        idle_id();
        step();

        // ---- MUL 7*6 unstalled ----
        drive_alu(4'b1101, 7, 6, 4);
        step();
        check("mul_busy_start", {31'd0, MulBusy_EX}, 1);
        drive_alu(4'b0010, 100, 100, 5);
        n = 0;
        while (MulBusy_EX && n < 60) begin
            n++;
            step();
        end
        check("mul_busy_cycles", n, 33);
        check("mul_result", Result_EX, 42);
        check("mul_dest_frozen", {27'd0, DestReg_EX}, 4);
        check("mul_regwrite", {31'd0, RegWrite_EX}, 1);
        step();
        check("after_mul_add", Result_EX, 200);
        check("after_mul_dest", {27'd0, DestReg_EX}, 5);
        idle_id();
        step();

        // ---- MUL with AnyStall held 3 cycles in DONE ----
        drive_alu(4'b1101, 7, 6, 4);
        step();
        idle_id();
        n = 0;
        while (MulBusy_EX && n < 60) begin
            n++;
            step();
        end
        check("mul2_busy_cycles", n, 33);
        AnyStall = 1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (Result_EX == 32'd42 && !MulBusy_EX) n++;
            if (k < 3) step();
        end
        AnyStall = 0;
        check("mul2_hold_cycles", n, 4);
        step();
        check("mul2_next_valid", {31'd0, Valid_EX}, 0);
        check("mul2_next_result", Result_EX, 0);

        // ---- reset at MUL iteration 10 ----
        drive_alu(4'b1101, 7, 6, 4);
        step();
        idle_id();
        for (int k = 0; k < 10; k++) step();
        check("mid_mul_busy", {31'd0, MulBusy_EX}, 1);
        reset = 1;
        #1;
        check("rst_mul_busy", {31'd0, MulBusy_EX}, 0);
        check("rst_mul_result", Result_EX, 0);
        check("rst_mul_valid", {31'd0, Valid_EX}, 0);
        check("rst_mul_dest", {27'd0, DestReg_EX}, 0);
        step();
        reset = 0;
        step();
        drive_alu(4'b0010, 5, 7, 3);
        step();
        check("post_rst_add", Result_EX, 12);
        check("post_rst_dest", {27'd0, DestReg_EX}, 3);
        check("post_rst_regwrite", {31'd0, RegWrite_EX}, 1);
        check("post_rst_busy", {31'd0, MulBusy_EX}, 0);
        idle_id();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
Execute stage (EX) of the pipelined MIPS core, directly downstream of decode. It latches decoded control and operands into an ID/EX register, computes ALU results, resolves branches and JR, and generates the RedirectPc_EX/BranchTaken_EX pair consumed by fetch. A multi-cycle iterative multiplier stalls the stage while it runs.

Parameters:
WIDTH, 32, datapath width; fixed at 32 for this core.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
AnyStall  in  1  global stall; hold ID/EX contents
Valid_ID  in  1  ID holds a real instruction
PcPlus4_ID  in  32  PC+4 of the ID instruction
RsData_ID, RtData_ID  in  32 each  register-file read data
Imm_ID  in  16  raw immediate
Rt_ID, Rd_ID  in  5 each  register specifiers
AluControl_ID  in  4  ALU op (encoding below)
BpCtl_ID  in  3  branch op (encoding below)
RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID  in  1 each  decode controls
Result_EX  out  32  ALU/link/multiply result
StoreData_EX  out  32  registered RtData for stores
DestReg_EX  out  5  writeback register
Valid_EX, RegWrite_EX, MemWrite_EX, MemToReg_EX  out  1 each  qualified controls for MEM
BranchTaken_EX  out  1  redirect fetch
RedirectPc_EX  out  32  redirect target
MulBusy_EX  out  1  multiply in progress; stage stall request

Behaviour:
- Reset (async): ID/EX register, multiplier FSM, counter and accumulator all cleared. All outputs 0.
- ID/EX update at posedge: hold if AnyStall or MulBusy_EX. Else load a bubble (Valid=0, all controls 0) if BranchTaken_EX. Else load the ID inputs.
- Latency: EX outputs are combinational from the ID/EX register, one cycle after ID.
- Write enables: RegWrite_EX, MemWrite_EX, MemToReg_EX and BranchTaken_EX are all ANDed with Valid_EX.
- DestReg_EX: 31 if Link, else Rd if RegDst, else Rt.
- Operand B: AluSrc ? extended Imm : RtData.
- Immediate extension: zero-extend for AND/OR/XOR; sign-extend otherwise.
- AluControl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is Imm[10:6], the shifted operand is RtData
  - 1000 SLTU, 1010 SUB, 1011 SLT, 1100 LUI (Imm<<16), 1101 MUL
  - all other codes produce 0
- Arithmetic: modulo 2^32, no overflow traps.
- Link: Result_EX = PcPlus4 + 4, overriding the ALU result.
- BpCtl encoding:
  - 000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 JR
  - Comparisons are signed on Rs, and against Rt for BEQ/BNE.
- Branch target: PcPlus4 + (sext(Imm)<<2). JR target: RsData.
- No delay slot; ID is squashed via the bubble. Fetch squashes its own IF instruction.
- Redirect during stall: BranchTaken_EX stays asserted for the whole stall; fetch treats a repeated redirect as idempotent.
- Multiplier FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE->BUSY when Valid_EX && op==MUL; MulBusy_EX=1 combinationally in that same cycle.
  - BUSY: 32 shift-add iterations on a 5-bit counter, one per cycle; MulBusy_EX=1.
  - On count 31, go to DONE. In DONE, MulBusy_EX=0 and Result_EX = low 32 bits of the product.
  - DONE->IDLE when the stage advances, i.e. !AnyStall. If AnyStall, DONE holds and the result is stable.
  - Total EX occupancy of an unstalled MUL: 34 cycles.
- Reset mid-multiply: FSM returns to IDLE, partial result discarded.

Decomposition:
- Package mips_pkg holds the AluControl and BpCtl encodings as localparams/typedefs, plus REG_RA=31. Decode shares the same package.
- One sub-module: mul_iter, which contains the FSM, counter and accumulator and exposes start/busy/done/product.

Test Plan:
- ADD: Rs=5, Rt=7, AluControl=0010, RegDst=1, Rd=3 -> one cycle later Result_EX=12, DestReg_EX=3, RegWrite_EX=1.
- BEQ taken: Rs=Rt=9, Imm=0x0004, PcPlus4=0x100 -> BranchTaken_EX=1, RedirectPc_EX=0x110. The next ID/EX load is a bubble (Valid_EX=0, RegWrite_EX=0).
- BNE not taken with Rs=Rt; JR with Rs=0x400 -> BranchTaken 0 for the BNE; for the JR, redirect to 0x400.
- MUL 7*6: MulBusy_EX high for 33 cycles with ID/EX frozen and ID inputs ignored, then Result_EX=42 for one cycle. With AnyStall held 3 extra cycles in DONE, 42 is held 4 cycles.
- JAL-style Link=1, PcPlus4=0x200 -> Result_EX=0x204, DestReg_EX=31.
- Reset asserted at MUL iteration 10 -> immediately all outputs 0, MulBusy_EX=0. After release the next ADD executes normally.
